// File: rtl/gemm_result_collector.sv
// Collects GEMM result rows during CMD_STREAM into a small FIFO and delivers them
// downstream over valid/ready, tagging the final row of each job.

package gemm_result_collector_pkg;
    typedef enum logic [1:0] {
        CMD_NONE   = 2'd0,
        CMD_LOAD   = 2'd1,
        CMD_STREAM = 2'd2,
        CMD_FLUSH  = 2'd3
    } command_t;
endpackage

module gemm_result_collector
    import gemm_result_collector_pkg::*;
#(
    parameter int unsigned SA_SIZE                = 2,
    parameter int unsigned WEIGHT_ACTIVATION_SIZE = 8,
    parameter int unsigned FIFO_DEPTH             = 4,
    parameter int unsigned MAX_ROWS               = 16,
    parameter int unsigned STALL_MARGIN           = 2
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic [$clog2(MAX_ROWS+1)-1:0]                     num_rows,
    input  command_t                                          sa_cmd,
    input  logic                                              sa_output_valid,
    input  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]    sa_outputs,
    output logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]    out_row,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic                                              out_last,
    output logic                                              stall_req,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              overflow
);

    localparam int unsigned RW = $clog2(MAX_ROWS + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] row_t;
    typedef enum logic [1:0] {StIdle, StCollect, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   rows_q, rows_d;
    logic [RW-1:0]   captured_q, captured_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic            overflow_q, overflow_d;

    row_t            row_mem  [FIFO_DEPTH];
    logic            last_mem [FIFO_DEPTH];

    logic push, pop, full, wr_en, drop, push_last;

    always_comb begin
        busy      = (state_q == StCollect) || (state_q == StDrain);
        done      = (state_q == StDone);
        out_valid = busy && (count_q != '0);
        pop       = out_valid && out_ready;
        push      = (state_q == StCollect) && sa_output_valid && (sa_cmd == CMD_STREAM);
        full      = (count_q == CW'(FIFO_DEPTH));
        // A pop in the same cycle frees the slot the push needs.
        wr_en     = push && (!full || pop);
        drop      = push && full && !pop;
        push_last = (RW'(captured_q + RW'(1)) == rows_q);
        out_row   = out_valid ? row_mem[rd_ptr_q] : '0;
        out_last  = out_valid && last_mem[rd_ptr_q];
        stall_req = busy && ((CW'(FIFO_DEPTH) - count_q) <= CW'(STALL_MARGIN));
        overflow  = overflow_q;
    end

    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        captured_d = captured_q;
        overflow_d = overflow_q;
        count_d    = count_q;

        if (wr_en && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - CW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    rows_d     = num_rows;
                    captured_d = '0;
                    overflow_d = 1'b0;
                    state_d    = (num_rows == '0) ? StDone : StCollect;
                end
            end
            StCollect: begin
                // Dropped rows still count so the job always terminates.
                if (push) begin
                    captured_d = captured_q + RW'(1);
                    if (captured_d == rows_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (count_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase

        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rows_q     <= '0;
            captured_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            captured_q <= captured_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Storage needs no reset: out_row is gated by out_valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            row_mem[wr_ptr_q]  <= sa_outputs;
            last_mem[wr_ptr_q] <= push_last;
        end
    end

endmodule

// File: tb/tb_gemm_result_collector.sv
// Self-checking bench for gemm_result_collector: directed scenarios plus random jobs,
// compared against a queue-based behavioural model.

module tb_gemm_result_collector;
    import gemm_result_collector_pkg::*;

    localparam int DEPTH  = 4;
    localparam int MARGIN = 2;
    localparam int RW     = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [RW-1:0]        num_rows;
    command_t             sa_cmd;
    logic                 sa_output_valid;
    logic [1:0][7:0]      sa_outputs;
    logic [1:0][7:0]      out_row;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 stall_req;
    logic                 busy;
    logic                 done;
    logic                 overflow;

    int n_pass  = 0;
    int n_total = 0;

    gemm_result_collector dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .num_rows        (num_rows),
        .sa_cmd          (sa_cmd),
        .sa_output_valid (sa_output_valid),
        .sa_outputs      (sa_outputs),
        .out_row         (out_row),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .stall_req       (stall_req),
        .busy            (busy),
        .done            (done),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: job phase, row queue, capture count, sticky overflow.
    typedef struct {
        logic [15:0] row;
        logic        last;
    } entry_t;

    entry_t q[$];
    int     m_phase;     // 0 idle, 1 collecting, 2 draining, 3 done pulse
    int     m_captured;
    int     m_rows;
    logic   m_ovf;

    function automatic void model_reset();
        q.delete();
        m_phase    = 0;
        m_captured = 0;
        m_rows     = 0;
        m_ovf      = 1'b0;
    endfunction

    function automatic void model_step(logic st, int nr, command_t c, logic v,
                                       logic [15:0] d, logic rdy);
        int     old_size;
        logic   active;
        logic   do_pop;
        logic   do_push;
        entry_t e;
        old_size = q.size();
        active   = (m_phase == 1) || (m_phase == 2);
        do_pop   = active && (old_size > 0) && rdy;
        do_push  = (m_phase == 1) && v && (c == CMD_STREAM);
        if (do_pop) q.delete(0);
        if (do_push) begin
            e.row  = d;
            e.last = (m_captured == m_rows - 1);
            if (q.size() < DEPTH) q.push_back(e);
            else m_ovf = 1'b1;
        end
        case (m_phase)
            0: if (st) begin
                m_rows     = nr;
                m_captured = 0;
                m_ovf      = 1'b0;
                m_phase    = (nr == 0) ? 3 : 1;
            end
            1: if (do_push) begin
                m_captured++;
                if (m_captured == m_rows) m_phase = 2;
            end
            2: if (old_size == 0) m_phase = 3;
            default: m_phase = 0;
        endcase
    endfunction

    // {out_valid, out_last, stall_req, busy, done, overflow, out_row}
    function automatic logic [21:0] exp_vec();
        logic        b;
        logic        ov;
        logic        lst;
        logic        st;
        logic [15:0] r;
        b   = (m_phase == 1) || (m_phase == 2);
        ov  = b && (q.size() > 0);
        r   = 16'h0;
        lst = 1'b0;
        if (ov) begin
            r   = q[0].row;
            lst = q[0].last;
        end
        st = b && ((DEPTH - q.size()) <= MARGIN);
        return {ov, lst, st, b, (m_phase == 3), m_ovf, r};
    endfunction

    function automatic logic [21:0] dut_vec();
        return {out_valid, out_last, stall_req, busy, done, overflow, out_row};
    endfunction

    // Apply one cycle of inputs at the falling edge, advance model, land on next falling edge.
    task automatic cyc(input logic r, input logic st, input int nr, input command_t c,
                       input logic v, input logic [15:0] d, input logic rdy);
        rst             = r;
        start           = st;
        num_rows        = nr[RW-1:0];
        sa_cmd          = c;
        sa_output_valid = v;
        sa_outputs      = d;
        out_ready       = rdy;
        if (r) model_reset();
        else model_step(st, nr, c, v, d, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b0, 0, CMD_NONE, 1'b0, 16'h0, 1'b0);
        cyc(1'b1, 1'b1, 3, CMD_STREAM, 1'b1, 16'hffff, 1'b1);
        n_total++;
        if (dut_vec() !== 22'h0) $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 22'h0);
        else n_pass++;
        cyc(1'b0, 1'b0, 0, CMD_NONE, 1'b0, 16'h0, 1'b0);
        n_total++;
        if (dut_vec() !== exp_vec()) $display("FAIL reset_idle: got %h expected %h", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_basic();
        int dones = 0;
        int lasts = 0;
        logic [15:0] rows [2];
        rows[0] = {8'd3, 8'd2};
        rows[1] = {8'd5, 8'd6};
        cyc(1'b0, 1'b1, 2, CMD_NONE, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (out_valid && out_last) lasts++;
            if (i < 2) cyc(1'b0, 1'b0, 0, CMD_STREAM, 1'b1, rows[i], 1'b1);
            else cyc(1'b0, 1'b0, 0, CMD_STREAM, 1'b0, 16'h0, 1'b1);
            if (done) dones++;
            n_total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL basic_cycle%0d: got %h expected %h", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        n_total++;
        if (dones != 1 || lasts != 1 || busy !== 1'b0)
            $display("FAIL basic_summary: done pulses %0d lasts %0d busy %b, expected 1 1 0",
                     dones, lasts, busy);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [15:0] head;
        cyc(1'b0, 1'b1, 4, CMD_NONE, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            if (i == 6) head = out_row;
            if (i < 4) cyc(1'b0, 1'b0, 0, CMD_STREAM, 1'b1, 16'($urandom), 1'b0);
            else cyc(1'b0, 1'b0, 0, CMD_STREAM, 1'b0, 16'h0, (i >= 6));
            n_total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL stall_cycle%0d: got %h expected %h", i, dut_vec(), exp_vec());
            else n_pass++;
            if (i == 1) begin
                n_total++;
                if (stall_req !== 1'b1) $display("FAIL stall_at_two: got %b expected 1", stall_req);
                else n_pass++;
            end
            if (i == 5) begin
                n_total++;
                if (out_row !== q[0].row || q.size() != 4)
                    $display("FAIL stall_hold: got %h expected %h", out_row, q[0].row);
                else n_pass++;
            end
        end
        n_total++;
        if (overflow !== 1'b0 || busy !== 1'b0)
            $display("FAIL stall_end: overflow %b busy %b expected 0 0", overflow, busy);
        else n_pass++;
    endtask

    task automatic test_overflow();
        int pops  = 0;
        int lasts = 0;
        int dones = 0;
        cyc(1'b0, 1'b1, 6, CMD_NONE, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 0, CMD_STREAM, (i < 6), 16'(16'h1100 + i), 1'b0);
            n_total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL ovf_fill%0d: got %h expected %h", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        n_total++;
        if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow);
        else n_pass++;
        for (int i = 0; i < 20 && m_phase != 0; i++) begin
            if (out_valid) begin
                pops++;
                if (out_last) lasts++;
            end
            cyc(1'b0, 1'b0, 0, CMD_NONE, 1'b0, 16'h0, 1'b1);
            if (done) dones++;
            n_total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL ovf_drain%0d: got %h expected %h", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        n_total++;
        if (pops != 4 || lasts != 0 || dones != 1)
            $display("FAIL ovf_summary: pops %0d lasts %0d dones %0d expected 4 0 1",
                     pops, lasts, dones);
        else n_pass++;
    endtask

    task automatic test_full_push_pop();
        logic [15:0] sent [6];
        logic [15:0] got  [$];
        for (int i = 0; i < 6; i++) sent[i] = 16'($urandom);
        cyc(1'b0, 1'b1, 6, CMD_NONE, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 16 && m_phase != 0; i++) begin
            if (out_valid && i >= 4) got.push_back(out_row);
            if (i < 6) cyc(1'b0, 1'b0, 0, CMD_STREAM, 1'b1, sent[i], (i >= 4));
            else cyc(1'b0, 1'b0, 0, CMD_NONE, 1'b0, 16'h0, 1'b1);
            n_total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL full_pp%0d: got %h expected %h", i, dut_vec(), exp_vec());
            else n_pass++;
            if (i == 5) begin
                n_total++;
                if (stall_req !== 1'b1 || overflow !== 1'b0 || out_row !== sent[2])
                    $display("FAIL full_pp_count: stall %b ovf %b head %h expected 1 0 %h",
                             stall_req, overflow, out_row, sent[2]);
                else n_pass++;
            end
        end
        n_total++;
        if (got.size() != 6 || got[0] !== sent[0] || got[5] !== sent[5])
            $display("FAIL full_pp_order: got %0d rows first %h last %h", got.size(),
                     (got.size() > 0) ? got[0] : 16'h0, (got.size() > 5) ? got[5] : 16'h0);
        else n_pass++;
    endtask

    task automatic test_ignore();
        int dones = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 0, CMD_STREAM, 1'b1, 16'(16'hab00 + i), 1'b1);
            n_total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL ign_idle%0d: got %h expected %h", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        cyc(1'b0, 1'b1, 2, CMD_NONE, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            case (i)
                0, 1:    cyc(1'b0, 1'b0, 0, CMD_NONE, 1'b1, 16'hdead, 1'b1);
                2:       cyc(1'b0, 1'b0, 0, CMD_LOAD, 1'b1, 16'hbeef, 1'b1);
                3:       cyc(1'b0, 1'b1, 7, CMD_NONE, 1'b0, 16'h0, 1'b1);
                4, 5:    cyc(1'b0, 1'b0, 0, CMD_STREAM, 1'b1, 16'(16'h0100 + i), 1'b1);
                default: cyc(1'b0, 1'b0, 0, CMD_NONE, 1'b0, 16'h0, 1'b1);
            endcase
            if (done) dones++;
            n_total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL ign_job%0d: got %h expected %h", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        n_total++;
        if (dones != 1) $display("FAIL ign_done_count: got %0d expected 1", dones);
        else n_pass++;
        cyc(1'b0, 1'b1, 0, CMD_NONE, 1'b0, 16'h0, 1'b1);
        n_total++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL zero_rows_done: done %b busy %b expected 1 0", done, busy);
        else n_pass++;
        cyc(1'b0, 1'b0, 0, CMD_NONE, 1'b0, 16'h0, 1'b1);
        n_total++;
        if (done !== 1'b0) $display("FAIL zero_rows_pulse: done %b expected 0", done);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        cyc(1'b0, 1'b1, 4, CMD_NONE, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 1'b0, 0, CMD_STREAM, 1'b1, 16'h1234, 1'b0);
        cyc(1'b0, 1'b0, 0, CMD_STREAM, 1'b1, 16'h5678, 1'b0);
        cyc(1'b1, 1'b0, 0, CMD_STREAM, 1'b1, 16'h9abc, 1'b0);
        n_total++;
        if (dut_vec() !== 22'h0) $display("FAIL midrst_outputs: got %h expected %h", dut_vec(), 22'h0);
        else n_pass++;
        cyc(1'b0, 1'b0, 0, CMD_NONE, 1'b0, 16'h0, 1'b1);
        n_total++;
        if (dut_vec() !== exp_vec()) $display("FAIL midrst_idle: got %h expected %h", dut_vec(), exp_vec());
        else n_pass++;
        cyc(1'b0, 1'b1, 3, CMD_NONE, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 0, CMD_STREAM, (i < 3), 16'(16'h4400 + i), 1'b1);
            if (done) dones++;
            n_total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL midrst_job%0d: got %h expected %h", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        n_total++;
        if (dones != 1) $display("FAIL midrst_done_count: got %0d expected 1", dones);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int job = 0; job < 20; job++) begin
            int nr;
            int cyc_used;
            nr       = $urandom_range(0, 8);
            cyc_used = 0;
            cyc(1'b0, 1'b1, nr, CMD_NONE, 1'b0, 16'h0, 1'b1);
            while (m_phase != 0 && cyc_used < 200) begin
                cyc(1'b0, ($urandom_range(0, 15) == 0), $urandom_range(0, 8),
                    ($urandom_range(0, 3) == 0) ? CMD_NONE : CMD_STREAM,
                    1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0));
                cyc_used++;
                n_total++;
                if (dut_vec() !== exp_vec())
                    $display("FAIL rand_job%0d_cyc%0d: got %h expected %h", job, cyc_used,
                             dut_vec(), exp_vec());
                else n_pass++;
            end
            if (m_phase != 0) begin
                n_total++;
                $display("FAIL rand_job%0d_timeout: model still in phase %0d", job, m_phase);
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        start           = 1'b0;
        num_rows        = '0;
        sa_cmd          = CMD_NONE;
        sa_output_valid = 1'b0;
        sa_outputs      = '0;
        out_ready       = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_full_push_pop();
        test_ignore();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
